// File: rtl/jogada_pkg.sv
// Shared constants, state encoding and choice acceptance rule for the
// four-player choice registry.
package jogada_pkg;

    localparam int N_PLAYERS = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    // Choice vectors up to 8 bits wide are zero-extended into selBits.
    function automatic logic choice_ok(input logic [7:0] selBits, input logic one_hot_chk);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            ones += int'(selBits[k]);
        end
        if (one_hot_chk) begin
            return (ones == 1);
        end
        return (ones != 0);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer followed by a registered rising-edge detector.
// A level already high when reset is released produces no pulse until it is released.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic [SYNC_STAGES:0]   realQ;
    logic                   prevQ;

    // realQ[SYNC_STAGES] marks that prevQ holds a sampled value rather than
    // a reset fill, so only a release actually seen on d can arm an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ <= '0;
            realQ <= '0;
            prevQ <= 1'b0;
            pulse <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], d};
            realQ <= {realQ[SYNC_STAGES-1:0], 1'b1};
            prevQ <= syncQ[SYNC_STAGES-1];
            pulse <= syncQ[SYNC_STAGES-1] & ~prevQ & realQ[SYNC_STAGES];
        end
    end

endmodule

// File: rtl/registo_jogadas.sv
// Collects one choice per player in turn and exposes all four together once
// the round is complete; choices stay hidden while the round is partial.
module registo_jogadas
    import jogada_pkg::*;
#(
    parameter int CHOICE_W    = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit ONE_HOT_CHK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHOICE_W-1:0] sel,
    input  logic                confirm,
    input  logic                clear,
    output logic [CHOICE_W-1:0] J1,
    output logic [CHOICE_W-1:0] J2,
    output logic [CHOICE_W-1:0] J3,
    output logic [CHOICE_W-1:0] J4,
    output logic [1:0]          player_idx,
    output logic                all_valid,
    output logic                err_invalid,
    output logic                stateDbg
);

    // Handshake: a confirm press becomes a single-cycle confP; it is consumed
    // in that same cycle together with the raw sel value, no back-pressure.
    state_t              state;
    state_t              stateNext;
    logic [1:0]          idxQ;
    logic [1:0]          idxNext;
    logic                storeEn;
    logic                errNext;
    logic                errQ;
    logic                confP;
    logic                selOk;
    logic [CHOICE_W-1:0] choiceQ [N_PLAYERS];

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_confirm_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (confirm),
        .pulse(confP)
    );

    assign selOk = choice_ok(8'(sel), ONE_HOT_CHK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            idxQ  <= '0;
            errQ  <= 1'b0;
        end else begin
            state <= stateNext;
            idxQ  <= idxNext;
            errQ  <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idxQ;
        storeEn   = 1'b0;
        errNext   = 1'b0;
        // clear wins over a press arriving in the same cycle
        if (clear) begin
            stateNext = COLLECT;
            idxNext   = '0;
        end else if (state == COLLECT && confP) begin
            if (selOk) begin
                storeEn = 1'b1;
                if (idxQ == 2'(N_PLAYERS - 1)) begin
                    stateNext = DONE;
                end else begin
                    idxNext = idxQ + 2'd1;
                end
            end else begin
                errNext = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                choiceQ[p] <= '0;
            end
        end else if (clear) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                choiceQ[p] <= '0;
            end
        end else if (storeEn) begin
            choiceQ[idxQ] <= sel;
        end
    end

    assign all_valid   = (state == DONE);
    assign player_idx  = idxQ;
    assign err_invalid = errQ;
    assign stateDbg    = state;

    assign J1 = all_valid ? choiceQ[0] : '0;
    assign J2 = all_valid ? choiceQ[1] : '0;
    assign J3 = all_valid ? choiceQ[2] : '0;
    assign J4 = all_valid ? choiceQ[3] : '0;

endmodule
